// File: rtl/rib_dtcm_responder_if.sv
// rtl/rib_dtcm_responder_if.sv - RIB load/store request/response bundle
//
// Purpose: groups the RIB request/grant and response handshake signals
// between the LSU initiator and the DTCM responder.
// Ports (signals):
//   req_i, we_i, addr_i, wdata_i, wstrb_i : request from the initiator
//   gnt_o                                 : responder accepts the request
//   rsp_valid_o, rsp_rdata_o, rsp_err_o   : registered response
//   rsp_ready_i                           : initiator accepts the response
//   busy_o                                : transaction in flight
interface rib_dtcm_responder_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req_i;
  logic                  we_i;
  logic [ADDR_WIDTH-1:0] addr_i;
  logic [DATA_WIDTH-1:0] wdata_i;
  logic [3:0]            wstrb_i;
  logic                  gnt_o;
  logic                  rsp_valid_o;
  logic [DATA_WIDTH-1:0] rsp_rdata_o;
  logic                  rsp_err_o;
  logic                  rsp_ready_i;
  logic                  busy_o;

  modport master (
    output req_i, we_i, addr_i, wdata_i, wstrb_i, rsp_ready_i,
    input  gnt_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, busy_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i, wstrb_i, rsp_ready_i,
    output gnt_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, busy_o
  );
endinterface

// File: rtl/rib_dtcm_responder.sv
// rtl/rib_dtcm_responder.sv - RIB bus responder serving a word-organised DTCM
//
// Purpose: accepts RIB read/write requests, applies WAIT_CYCLES wait states,
// accesses the internal data SRAM (byte-strobed writes) and returns a
// registered, back-pressurable response.
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous active-low reset
//   bus : rib_dtcm_responder_if.slave (request, grant, response, busy)
module rib_dtcm_responder #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    DEPTH_WORDS = 4096,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h1000_0000,
  parameter int                    WAIT_CYCLES = 0
) (
  input  logic                clk,
  input  logic                rst,
  rib_dtcm_responder_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int AW1   = ADDR_WIDTH + 1;
  // One bit wider than the address so the window end cannot wrap.
  localparam logic [AW1-1:0] END_ADDR  = {1'b0, BASE_ADDR} + AW1'(4 * DEPTH_WORDS);
  localparam logic [AW1-1:0] BASE_EXT  = {1'b0, BASE_ADDR};
  localparam bit             HAS_WAIT  = (WAIT_CYCLES > 0);
  localparam logic [3:0]     WAIT_LOAD = HAS_WAIT ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [3:0]            wait_cnt_q;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [3:0]            wstrb_q;
  logic [IDX_W-1:0]      idx_q;
  logic                  err_q;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  rsp_err_q;

  logic                  gnt;
  logic                  accept;
  logic [IDX_W-1:0]      idx_d;
  logic                  err_d;
  logic [AW1-1:0]        addr_ext;

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  // In RESP the response is always valid, so ready alone completes the
  // handshake and frees the slot for a back-to-back request.
  assign gnt    = (state_q == ST_IDLE) || ((state_q == ST_RESP) && bus.rsp_ready_i);
  assign accept = bus.req_i && gnt;

  assign addr_ext = {1'b0, bus.addr_i};
  assign err_d    = (addr_ext < BASE_EXT) || (addr_ext >= END_ADDR);
  // Out-of-window addresses produce a wrapped index; err gates its use.
  assign idx_d    = IDX_W'((bus.addr_i - BASE_ADDR) >> 2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   state_d = ST_IDLE;
      ST_WAIT:   if (wait_cnt_q == 4'd0) state_d = ST_ACCESS;
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   if (bus.rsp_ready_i) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (accept) begin
      state_d = HAS_WAIT ? ST_WAIT : ST_ACCESS;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_q  <= 4'd0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      wstrb_q     <= 4'd0;
      idx_q       <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      if (accept) begin
        we_q       <= bus.we_i;
        wdata_q    <= bus.wdata_i;
        wstrb_q    <= bus.wstrb_i;
        idx_q      <= idx_d;
        err_q      <= err_d;
        wait_cnt_q <= WAIT_LOAD;
      end else if ((state_q == ST_WAIT) && (wait_cnt_q != 4'd0)) begin
        wait_cnt_q <= wait_cnt_q - 4'd1;
      end

      if (state_q == ST_ACCESS) begin
        rsp_valid_q <= 1'b1;
        rsp_rdata_q <= (!we_q && !err_q) ? mem[idx_q] : '0;
        rsp_err_q   <= err_q;
      end else if ((state_q == ST_RESP) && bus.rsp_ready_i) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  // SRAM array is deliberately not reset; only the ACCESS state writes it,
  // so a transaction dropped by reset before ACCESS never touches memory.
  always_ff @(posedge clk) begin
    if ((state_q == ST_ACCESS) && we_q && !err_q) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_q[b]) begin
          mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

  assign bus.gnt_o       = gnt;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_rdata_o = rsp_rdata_q;
  assign bus.rsp_err_o   = rsp_err_q;
  assign bus.busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rib_dtcm_responder.sv
// tb/tb_rib_dtcm_responder.sv - scoreboard bench for rib_dtcm_responder
module tb_rib_dtcm_responder;

  localparam longint BASE  = 64'h1000_0000;
  localparam longint DEPTH = 4096;

  logic clk;
  logic rst;
  logic sel;
  logic req, we;
  logic [31:0] addr, wdata;
  logic [3:0]  wstrb;
  logic ready;
  int   ready_mode;
  logic ready_manual;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_acc = 0;
  int hs_edge  = -1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc_cyc;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  logic [31:0] mem0 [int];
  logic [31:0] mem3 [int];

  int          pool [8] = '{0, 1, 4, 8, 9, 15, 100, 4095};
  logic [31:0] oob  [4] = '{32'h0FFF_FFFC, 32'h1000_4000, 32'h1000_4010, 32'hFFFF_FFFC};

  rib_dtcm_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();
  rib_dtcm_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus3 ();

  rib_dtcm_responder #(.WAIT_CYCLES(0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  rib_dtcm_responder #(.WAIT_CYCLES(3)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

  assign bus0.req_i       = req & ~sel;
  assign bus0.we_i        = we;
  assign bus0.addr_i      = addr;
  assign bus0.wdata_i     = wdata;
  assign bus0.wstrb_i     = wstrb;
  assign bus0.rsp_ready_i = sel ? 1'b1 : ready;
  assign bus3.req_i       = req & sel;
  assign bus3.we_i        = we;
  assign bus3.addr_i      = addr;
  assign bus3.wdata_i     = wdata;
  assign bus3.wstrb_i     = wstrb;
  assign bus3.rsp_ready_i = sel ? ready : 1'b1;

  logic        m_gnt, m_valid, m_err, m_busy;
  logic [31:0] m_rdata;
  assign m_gnt   = sel ? bus3.gnt_o       : bus0.gnt_o;
  assign m_valid = sel ? bus3.rsp_valid_o : bus0.rsp_valid_o;
  assign m_rdata = sel ? bus3.rsp_rdata_o : bus0.rsp_rdata_o;
  assign m_err   = sel ? bus3.rsp_err_o   : bus0.rsp_err_o;
  assign m_busy  = sel ? bus3.busy_o      : bus0.busy_o;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: window check, word index and byte-lane merge.
  function automatic exp_t model(input logic s, input logic w, input logic [31:0] a,
                                 input logic [31:0] d, input logic [3:0] st);
    exp_t   e;
    longint ua;
    int     idx;
    logic [31:0] word;
    ua      = longint'(a);
    e.err   = (ua < BASE) || (ua >= BASE + 4 * DEPTH);
    e.rdata = 32'h0;
    e.lat   = s ? 4 : 1;
    e.acc_cyc = 0;
    if (!e.err) begin
      idx  = int'((ua - BASE) / 4);
      word = s ? mem3[idx] : mem0[idx];
      if (w) begin
        for (int b = 0; b < 4; b++) if (st[b]) word[8*b +: 8] = d[8*b +: 8];
        if (s) mem3[idx] = word; else mem0[idx] = word;
      end else begin
        e.rdata = word;
      end
    end
    return e;
  endfunction

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] st);
    int   g;
    exp_t e;
    g = 0;
    req = 1'b1; we = w; addr = a; wdata = d; wstrb = st;
    while (!m_gnt && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (!m_gnt) begin
      total++; bad++;
      $display("FAIL grant_timeout: got gnt=0 expected gnt=1 addr %h", a);
      req = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    e = model(sel, w, a, d, st);
    e.acc_cyc = cyc;
    last_acc  = cyc;
    exp_q.push_back(e);
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while ((exp_q.size() != 0 || m_busy) && g < 500) begin
      @(negedge clk);
      g++;
    end
    chk("drain_idle", {31'd0, (exp_q.size() == 0) && !m_busy}, 32'd1);
  endtask

  task automatic run_suite();
    logic [31:0] a;
    ready_mode = 0;
    foreach (pool[i]) issue(1'b1, 32'(BASE) + 32'(pool[i] * 4), $urandom, 4'hF);
    issue(1'b1, 32'h1000_0010, 32'hDEAD_BEEF, 4'hF);
    issue(1'b0, 32'h1000_0010, 32'h0, 4'hF);
    issue(1'b1, 32'h1000_0020, 32'h1122_3344, 4'hF);
    issue(1'b1, 32'h1000_0020, 32'hAABB_CCDD, 4'b0100);
    issue(1'b0, 32'h1000_0020, 32'h0, 4'hF);
    issue(1'b0, 32'h0FFF_FFFC, 32'h0, 4'hF);
    issue(1'b1, 32'h1000_4000, 32'hFFFF_FFFF, 4'hF);
    issue(1'b0, 32'h1000_0000, 32'h0, 4'hF);
    issue(1'b0, 32'h1000_3FFC, 32'h0, 4'hF);
    issue(1'b1, 32'h1000_0010, 32'h1234_5678, 4'h0);
    issue(1'b0, 32'h1000_0010, 32'h0, 4'hF);
    wait_idle();
    ready_mode = 1;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(7) == 0) a = oob[$urandom_range(3)];
      else a = 32'(BASE) + 32'(pool[$urandom_range(7)] * 4) + 32'($urandom_range(3));
      issue(1'($urandom_range(1)), a, $urandom, 4'($urandom_range(15)));
    end
    wait_idle();
    ready_mode = 0;
    @(negedge clk);
  endtask

  initial begin
    ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       ready = 1'b1;
        1:       ready = ($urandom_range(3) != 0);
        default: ready = ready_manual;
      endcase
    end
  end

  // Monitor: pops the scoreboard on the first cycle of each response and
  // checks that the response is held while stalled.
  initial begin
    logic        fresh;
    logic [31:0] held_rdata;
    logic        held_err;
    exp_t        e;
    fresh = 1'b1;
    held_rdata = 32'h0;
    held_err = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        fresh = 1'b1;
      end else if (m_valid) begin
        if (fresh) begin
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_rsp: got rdata %h err %b expected no response", m_rdata, m_err);
          end else begin
            e = exp_q.pop_front();
            chk("rsp_rdata", m_rdata, e.rdata);
            chk("rsp_err", {31'd0, m_err}, {31'd0, e.err});
            chk("rsp_latency", 32'(cyc - e.acc_cyc), 32'(e.lat));
          end
          held_rdata = m_rdata;
          held_err   = m_err;
          fresh      = 1'b0;
        end else begin
          chk("hold_rdata", m_rdata, held_rdata);
          chk("hold_err", {31'd0, m_err}, {31'd0, held_err});
        end
        chk("busy_in_resp", {31'd0, m_busy}, 32'd1);
        if (!ready) begin
          chk("gnt_while_stalled", {31'd0, m_gnt}, 32'd0);
        end else begin
          fresh   = 1'b1;
          hs_edge = cyc + 1;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    rst = 1'b0; sel = 1'b0; req = 1'b0; we = 1'b0;
    addr = 32'h0; wdata = 32'h0; wstrb = 4'h0;
    ready_mode = 0; ready_manual = 1'b1;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      #1;
      chk("reset_valid", {31'd0, m_valid}, 32'd0);
      chk("reset_rdata", m_rdata, 32'd0);
      chk("reset_err", {31'd0, m_err}, 32'd0);
      chk("reset_busy", {31'd0, m_busy}, 32'd0);
    end
    sel = 1'b0;
    rst = 1'b1;
    #1;
    chk("gnt_after_reset", {31'd0, m_gnt}, 32'd1);
    @(negedge clk);

    run_suite();
    sel = 1'b1;
    @(negedge clk);
    run_suite();

    // Back-pressure with wait states and a back-to-back accept.
    ready_mode = 2; ready_manual = 1'b0;
    repeat (2) @(negedge clk);
    fork
      begin
        issue(1'b0, 32'h1000_0020, 32'h0, 4'hF);
        issue(1'b0, 32'h1000_0024, 32'h0, 4'hF);
      end
      begin
        repeat (10) @(negedge clk);
        ready_manual = 1'b1;
      end
    join
    chk("b2b_accept_edge", 32'(last_acc), 32'(hs_edge));
    wait_idle();
    ready_mode = 0;

    // Reset during WAIT of a write.
    issue(1'b1, 32'h1000_0040, 32'hC3C3_C3C3, 4'hF);
    wait_idle();
    req = 1'b1; we = 1'b1; addr = 32'h1000_0040; wdata = 32'h5A5A_5A5A; wstrb = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    #2;
    chk("busy_in_wait", {31'd0, m_busy}, 32'd1);
    rst = 1'b0;
    #1;
    chk("rst_wait_busy", {31'd0, m_busy}, 32'd0);
    chk("rst_wait_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_wait_rdata", m_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("gnt_after_rst_wait", {31'd0, m_gnt}, 32'd1);
    @(negedge clk);

    // Reset while a read response is stalled: outputs clear asynchronously.
    ready_mode = 2; ready_manual = 1'b0;
    repeat (2) @(negedge clk);
    issue(1'b0, 32'h1000_0040, 32'h0, 4'hF);
    g = 0;
    while (!m_valid && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("stalled_rsp_seen", {31'd0, m_valid}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_resp_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_resp_rdata", m_rdata, 32'd0);
    chk("rst_resp_err", {31'd0, m_err}, 32'd0);
    chk("rst_resp_busy", {31'd0, m_busy}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    ready_mode = 0;
    @(negedge clk);
    @(negedge clk);
    issue(1'b0, 32'h1000_0040, 32'h0, 4'hF);
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rib_dtcm_responder.md
Name: rib_dtcm_responder

Overview:
Bus responder (slave) side of the RIB load/store interface: accepts read and write requests issued by the AGU/LSU and serves them from an internal word-organised data SRAM. Sits between the core's memory request port and the data tightly-coupled memory. Uses a request/grant handshake, a programmable wait-state counter and a registered, back-pressurable response channel. The initiator has already merged sub-word data for byte and halfword stores, so this block writes whole words under a byte strobe.

Parameters:
ADDR_WIDTH, 32, request address width
DATA_WIDTH, 32, data width; fixed 4 byte lanes
DEPTH_WORDS, 4096, SRAM depth in words; power of two
BASE_ADDR, 32'h1000_0000, byte address of word 0; aligned to 4*DEPTH_WORDS
WAIT_CYCLES, 0, extra wait states per access (0..15)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
req_i  in  1  request valid (RIB_REQ)
we_i  in  1  1 = write, 0 = read
addr_i  in  ADDR_WIDTH  byte address; bits [1:0] ignored
wdata_i  in  DATA_WIDTH  write word
wstrb_i  in  4  byte-lane write enables, bit n = wdata_i[8n+7:8n]
gnt_o  out  1  request accepted this cycle when req_i & gnt_o
rsp_valid_o  out  1  response valid
rsp_rdata_o  out  DATA_WIDTH  read data; 0 for writes and errors
rsp_err_o  out  1  address outside the SRAM window
rsp_ready_i  in  1  initiator accepts the response
busy_o  out  1  transaction in flight (state != IDLE)

Behaviour:
- Reset (rst low, asynchronous): state = IDLE, wait counter = 0, rsp_valid_o = 0, rsp_rdata_o = 0, rsp_err_o = 0, all latched request fields = 0. busy_o = 0; gnt_o = 1 as soon as reset is released. SRAM contents are not reset.
- States: IDLE, WAIT, ACCESS, RESP.
- gnt_o is combinational: high in IDLE, or in RESP when rsp_ready_i = 1. Low in WAIT and ACCESS.
- Accept (req_i & gnt_o at a clock edge):
  - latch we_i, wdata_i, wstrb_i and word index = (addr_i - BASE_ADDR) >> 2;
  - err = (addr_i < BASE_ADDR) or (addr_i >= BASE_ADDR + 4*DEPTH_WORDS);
  - next state = WAIT if WAIT_CYCLES > 0, else ACCESS;
  - the counter loads WAIT_CYCLES-1.
- WAIT: counter decrements each cycle; go to ACCESS when it reaches 0.
- ACCESS (one cycle):
  - write, no err: for each set strobe bit, write that byte lane of the word; other lanes keep their value;
  - write with wstrb_i = 0: memory unchanged, normal response;
  - read, no err: register the addressed word into rsp_rdata_o;
  - err, or any write: rsp_rdata_o = 0, no memory change, rsp_err_o = err;
  - then go to RESP with rsp_valid_o = 1.
- Latency: accept edge E gives rsp_valid_o high after edge E+1+WAIT_CYCLES. A read issued after a write to the same word returns the written data.
- RESP: rsp_valid_o, rsp_rdata_o and rsp_err_o are held stable until rsp_valid_o & rsp_ready_i.
  - On that handshake with no new accept: rsp_valid_o = 0, go to IDLE.
  - On that handshake with req_i in the same cycle: the new request is accepted (back-to-back) and rsp_valid_o drops on the same edge.
  - Peak throughput: one transaction per 2+WAIT_CYCLES cycles.
- Requests while gnt_o = 0 are ignored; the initiator holds req_i and all request fields stable until granted.
- Reset mid-transaction: the in-flight transaction is dropped. A write that has not yet reached ACCESS leaves memory untouched. No response is produced.

Test Plan:
- WAIT_CYCLES=0: write 0xDEADBEEF to 0x1000_0010 with wstrb 4'hF, then read it back -> each response arrives 1 cycle after accept; read returns rdata 0xDEADBEEF, err 0.
- Byte strobe: word at 0x1000_0020 = 0x11223344; write 0xAABBCCDD with wstrb 4'b0100; read -> 0x11BB3344.
- Out of range: read 0x0FFF_FFFC, and write to BASE_ADDR + 4*DEPTH_WORDS -> rsp_err_o = 1, rdata 0, memory unchanged (a check read of word 0 is unaffected).
- Back-pressure with WAIT_CYCLES=3: hold rsp_ready_i low for 5 cycles -> rsp_valid_o is asserted 4 cycles after accept; rdata and err stay stable; gnt_o = 0 until ready; a second req_i issued with ready is accepted on the handshake edge.
- Zero strobe: write with wstrb 4'h0 -> response err 0, memory unchanged.
- Reset: assert rst during WAIT of a write of 0x5A5A5A5A with WAIT_CYCLES=3 -> all outputs return to 0 asynchronously; after release the target word still holds its old value; gnt_o = 1.
